ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED "set LEDs" or 0xF4 "enable") from the MiniAlu system to the keyboard over the same two open-drain lines the keyboard receiver listens on. The block inhibits the bus, issues the start bit, shifts the byte out LSB-first with odd parity on device-generated clock edges, then checks the device ACK. It also tells the receiver to ignore the bus while a transfer is in progress.

---
 rtl/ps2_host_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device command transmitter with ACK check.
//            Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       iSend,
    input  logic [7:0] iData,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE,
    output logic       oBusy,
    output logic       oRxInhibit,
    output logic       oDone,
    output logic       oError
);

    localparam int                 c_INH_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_INH_W-1:0] c_INH_PRE  = c_INH_W'(INHIBIT_CYCLES - 2);

    // The start bit is raised one cycle before inhibit ends, so at least two cycles are needed.
    if (INHIBIT_CYCLES < 2 || FILTER_LEN < 2 || TIMEOUT_CYCLES < 1) begin : g_badParams
        $error("ps2_host_tx: INHIBIT_CYCLES and FILTER_LEN must be >= 2, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_PARITY    = 3'd4,
        S_STOP      = 3'd5,
        S_WAIT_IDLE = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    logic [1:0]            r_clkSync;
    logic [1:0]            r_dataSync;
    logic [FILTER_LEN-1:0] r_clkFilt;
    logic [FILTER_LEN-1:0] r_dataFilt;
    logic                  r_clkLvl;
    logic                  r_dataLvl;
    logic                  w_fclkFall;

    state_t                r_state;
    logic [7:0]            r_shift;
    logic                  r_parity;
    logic [3:0]            r_bitCnt;
    logic [c_INH_W-1:0]    r_inhCnt;
    logic                  r_clkOe;
    logic                  r_dataOe;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    // Idle bus level is high, so the conditioning chain resets to 1 to avoid a spurious edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_clkSync  <= '1;
            r_dataSync <= '1;
            r_clkFilt  <= '1;
            r_dataFilt <= '1;
            r_clkLvl   <= 1'b1;
            r_dataLvl  <= 1'b1;
        end else begin
            r_clkSync  <= {r_clkSync[0], iPS2_CLK};
            r_dataSync <= {r_dataSync[0], iPS2_DATA};
            r_clkFilt  <= {r_clkFilt[FILTER_LEN-2:0], r_clkSync[1]};
            r_dataFilt <= {r_dataFilt[FILTER_LEN-2:0], r_dataSync[1]};
            if (&r_clkFilt)
                r_clkLvl <= 1'b1;
            else if (~|r_clkFilt)
                r_clkLvl <= 1'b0;
            if (&r_dataFilt)
                r_dataLvl <= 1'b1;
            else if (~|r_dataFilt)
                r_dataLvl <= 1'b0;
        end
    end

    assign w_fclkFall = r_clkLvl & ~|r_clkFilt;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] r_wdog;
    logic              w_wdActive;
    logic              w_wdExpire;

    assign w_wdActive = r_state inside {S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE};
    assign w_wdExpire = w_wdActive && (r_wdog == c_WD_LAST);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            r_wdog <= '0;
        else if (w_wdActive)
            r_wdog <= r_wdog + 1'b1;
        else
            r_wdog <= '0;
    end
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_bitCnt <= '0;
            r_inhCnt <= '0;
            r_clkOe  <= 1'b0;
            r_dataOe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            if (w_wdExpire) begin
                r_clkOe  <= 1'b0;
                r_dataOe <= 1'b0;
                r_busy   <= 1'b0;
                r_error  <= 1'b1;
                r_state  <= S_IDLE;
            end else
`endif
            begin
                case (r_state)
                    S_IDLE: begin
                        r_clkOe  <= 1'b0;
                        r_dataOe <= 1'b0;
                        if (iSend) begin
                            r_shift  <= iData;
                            r_parity <= ~^iData;
                            r_bitCnt <= '0;
                            r_inhCnt <= '0;
                            r_clkOe  <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        r_inhCnt <= r_inhCnt + 1'b1;
                        if (r_inhCnt == c_INH_PRE)
                            r_dataOe <= 1'b1;
                        if (r_inhCnt == c_INH_LAST) begin
                            r_clkOe <= 1'b0;
                            r_state <= S_START;
                        end
                    end
                    S_START: begin
                        if (w_fclkFall) begin
                            r_dataOe <= ~r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_bitCnt <= 4'd1;
                            r_state  <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_fclkFall) begin
                            if (r_bitCnt == 4'd8) begin
                                r_dataOe <= ~r_parity;
                                r_state  <= S_PARITY;
                            end else begin
                                r_dataOe <= ~r_shift[0];
                                r_shift  <= r_shift >> 1;
                                r_bitCnt <= r_bitCnt + 4'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (w_fclkFall) begin
                            r_dataOe <= 1'b0;
                            r_state  <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (w_fclkFall)
                            r_state <= r_dataLvl ? S_FAIL : S_WAIT_IDLE;
                    end
                    S_WAIT_IDLE: begin
                        if (r_clkLvl && r_dataLvl) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_FAIL: begin
                        r_clkOe  <= 1'b0;
                        r_dataOe <= 1'b0;
                        if (r_clkLvl && r_dataLvl) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_clkOe  <= 1'b0;
                        r_dataOe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign oPS2_CLK_OE  = r_clkOe;
    assign oPS2_DATA_OE = r_dataOe;
    assign oBusy        = r_busy;
    assign oRxInhibit   = r_busy;
    assign oDone        = r_done;
    assign oError       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with an open-drain device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int c_INH  = 20;
    localparam int c_TMO  = 4000;
    localparam int c_FLT  = 8;
    localparam int c_HALF = 100;

    logic       Clock      = 1'b0;
    logic       Reset_n    = 1'b1;
    logic       iSend      = 1'b0;
    logic [7:0] iData      = 8'h00;
    logic       devClkLow  = 1'b0;
    logic       devDataLow = 1'b0;
    logic       oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oRxInhibit, oDone, oError;
    logic       w_ps2Clk, w_ps2Data;

    assign w_ps2Clk  = ~(oPS2_CLK_OE | devClkLow);
    assign w_ps2Data = ~(oPS2_DATA_OE | devDataLow);

    ps2_host_tx #(
        .INHIBIT_CYCLES(c_INH),
        .TIMEOUT_CYCLES(c_TMO),
        .FILTER_LEN    (c_FLT)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .iSend       (iSend),
        .iData       (iData),
        .iPS2_CLK    (w_ps2Clk),
        .iPS2_DATA   (w_ps2Data),
        .oPS2_CLK_OE (oPS2_CLK_OE),
        .oPS2_DATA_OE(oPS2_DATA_OE),
        .oBusy       (oBusy),
        .oRxInhibit  (oRxInhibit),
        .oDone       (oDone),
        .oError      (oError)
    );

    always #5 Clock = ~Clock;

    int   nVec = 0, nMis = 0;
    int   doneCnt = 0, errCnt = 0, badWidth = 0, badExcl = 0, badBusy = 0, badRx = 0;
    int   inhRun = 0, lastInh = 0;
    logic prevDone = 1'b0, prevErr = 1'b0;

    // Protocol watchers for pulse shape, exclusivity and inhibit length.
    always @(negedge Clock) begin
        if (oDone) doneCnt++;
        if (oError) errCnt++;
        if ((oDone && prevDone) || (oError && prevErr)) badWidth++;
        if (oDone && oError) badExcl++;
        if ((oDone || oError) && oBusy) badBusy++;
        if (oRxInhibit !== oBusy) badRx++;
        prevDone = oDone;
        prevErr  = oError;
        if (oPS2_CLK_OE) inhRun++;
        else if (inhRun != 0) begin
            lastInh = inhRun;
            inhRun  = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bus frame: data LSB-first, odd parity, stop bit.
    function automatic logic [9:0] expFrame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    task automatic devTransfer(input bit ack, input int nClocks, output logic [10:0] samp,
                               output logic startBit, output bit ok);
        int t;
        samp = '0; startBit = 1'b1; ok = 1'b0;
        t = 0;
        while (!oPS2_CLK_OE && t < 200) begin @(negedge Clock); t++; end
        if (!oPS2_CLK_OE) return;
        t = 0;
        while (oPS2_CLK_OE && t < 1000) begin @(negedge Clock); t++; end
        if (oPS2_CLK_OE) return;
        startBit = w_ps2Data;
        ok = 1'b1;
        repeat (c_HALF) @(negedge Clock);
        for (int k = 1; k <= nClocks; k++) begin
            devClkLow = 1'b1;
            if (k == nClocks && nClocks < 11) begin
                repeat (c_HALF / 2) @(negedge Clock);
                return;
            end
            repeat (c_HALF) @(negedge Clock);
            devClkLow = 1'b0;
            samp[k-1] = w_ps2Data;
            if (k == 11) devDataLow = 1'b0;
            repeat (c_HALF / 2) @(negedge Clock);
            if (k == 10 && ack) devDataLow = 1'b1;
            repeat (c_HALF / 2) @(negedge Clock);
        end
    endtask

    task automatic sendByte(input logic [7:0] d);
        @(negedge Clock);
        iData = d;
        iSend = 1'b1;
        @(negedge Clock);
        iSend = 1'b0;
        check("accept", {oBusy, oRxInhibit, oPS2_CLK_OE}, 3'b111);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int t = 0;
        while (oBusy && t < budget) begin @(negedge Clock); t++; end
        check(tag, oBusy, 0);
    endtask

    task automatic runXfer(input logic [7:0] d, input bit ack, input bit poke);
        logic [10:0] samp;
        logic        sb;
        bit          ok;
        int          d0, e0;
        logic [9:0]  f;
        f = expFrame(d); d0 = doneCnt; e0 = errCnt; lastInh = 0;
        fork
            devTransfer(ack, 11, samp, sb, ok);
            sendByte(d);
            if (poke) begin
                repeat (600) @(negedge Clock);
                iData = 8'h55; iSend = 1'b1;
                @(negedge Clock);
                iSend = 1'b0;
            end
        join
        waitIdle(400, "xfer_idle");
        check("dev_handshake", ok, 1);
        check("start_bit", sb, 0);
        check("inhibit_len", lastInh, c_INH);
        check("frame_bits", samp[9:0], f);
        check("done_cnt", doneCnt - d0, ack);
        check("error_cnt", errCnt - e0, !ack);
        check("oe_released", {oPS2_CLK_OE, oPS2_DATA_OE}, 0);
        if (poke) begin
            repeat (300) @(negedge Clock);
            check("poke_ignored", oBusy, 0);
        end
    endtask

    task automatic runTimeout();
        int t;
        int e0 = errCnt;
        int d0 = doneCnt;
        sendByte(8'hF4);
        t = 0;
        while (oPS2_CLK_OE && t < 100) begin @(negedge Clock); t++; end
        t = 0;
`ifdef PS2_TX_TIMEOUT_EN
        while (!oError && t < c_TMO + 100) begin @(negedge Clock); t++; end
        check("wd_latency", t, c_TMO);
        @(negedge Clock);
        check("wd_err_cnt", errCnt - e0, 1);
        check("wd_idle", {oBusy, oPS2_CLK_OE, oPS2_DATA_OE}, 0);
        check("wd_no_done", doneCnt - d0, 0);
`else
        repeat (c_TMO + 1000) @(negedge Clock);
        check("hold_busy", oBusy, 1);
        check("hold_no_err", errCnt - e0, 0);
        check("hold_no_done", doneCnt - d0, 0);
        Reset_n = 1'b0;
        repeat (3) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (20) @(negedge Clock);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] samp;
        logic        sb;
        bit          ok;
        logic [7:0]  rnd;
        #2 Reset_n = 1'b0;
        #1 check("reset_outputs", {oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oRxInhibit, oDone, oError}, 0);
        repeat (5) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (20) @(negedge Clock);

        runXfer(8'hED, 1'b1, 1'b0);
        runXfer(8'hF4, 1'b1, 1'b0);
        runXfer(8'hA7, 1'b0, 1'b0);
        runTimeout();

        fork
            devTransfer(1'b1, 5, samp, sb, ok);
            sendByte(8'hED);
        join
        check("mid_busy", oBusy, 1);
        #2 Reset_n = 1'b0;
        #1 check("async_reset", {oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oRxInhibit, oDone, oError}, 0);
        devClkLow  = 1'b0;
        devDataLow = 1'b0;
        repeat (5) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (20) @(negedge Clock);
        runXfer(8'hF4, 1'b1, 1'b0);

        runXfer(8'hED, 1'b1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            rnd = 8'($urandom);
            runXfer(rnd, ($urandom_range(0, 3) != 0), 1'b0);
        end

        check("pulse_width", badWidth, 0);
        check("done_err_excl", badExcl, 0);
        check("busy_drop", badBusy, 0);
        check("rxinhibit_eq_busy", badRx, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
